// File: rtl/data_mem_hs_if.sv
// Load/store request/acknowledge bundle between a core's memory port and data_mem_hs.
// The core drives the request side; the memory drives ready/ack/data/error.
interface data_mem_hs_if;
  logic        iReq;
  logic        iWrite;
  logic [31:0] iAddr;
  logic [3:0]  iByteEn;
  logic [31:0] iWriteData;
  logic        oReady;
  logic        oAck;
  logic [31:0] oReadData;
  logic        oError;

  modport master (
    output iReq, iWrite, iAddr, iByteEn, iWriteData,
    input  oReady, oAck, oReadData, oError
  );

  modport slave (
    input  iReq, iWrite, iAddr, iByteEn, iWriteData,
    output oReady, oAck, oReadData, oError
  );
endinterface

// File: rtl/data_mem_hs.sv
// Word-organised data RAM with req/ack handshake, programmable wait states,
// byte-lane stores and out-of-range error reporting.
//
// state | meaning
// IDLE  | ready, no transaction in flight
// WAIT  | request captured, counting wait states, not ready
// ACK   | completion pulse; ready, so a new request may be accepted back-to-back
module data_mem_hs #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic         clk,
  input logic         reset,
  data_mem_hs_if.slave bus
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH32 = 32'(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1  = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t      state, stateNext;
  logic [3:0]  cnt, cntNext;
  logic        accept, commit;

  logic [31:0] addrReg, dataReg;
  logic        writeReg;
  logic [3:0]  byteEnReg;

  logic [31:0] effAddr, effData, offset, word;
  logic        effWrite, effError;
  logic [3:0]  effByteEn;
  logic [AW-1:0] effIdx;

  logic [31:0] readData;
  logic        errReg;
  logic [31:0] mem [DEPTH_WORDS];

  assign bus.oReady    = (state != WAIT);
  assign bus.oAck      = (state == ACK);
  assign bus.oError    = (state == ACK) & errReg;
  assign bus.oReadData = readData;
  assign accept        = bus.iReq & bus.oReady;

  // Commit from WAIT uses the captured request; a zero-latency commit uses the live inputs.
  always_comb begin
    effAddr   = bus.iAddr;
    effData   = bus.iWriteData;
    effWrite  = bus.iWrite;
    effByteEn = bus.iByteEn;
    if (state == WAIT) begin
      effAddr   = addrReg;
      effData   = dataReg;
      effWrite  = writeReg;
      effByteEn = byteEnReg;
    end
    offset   = effAddr - BASE_ADDR;
    word     = offset >> 2;
    effError = (effAddr < BASE_ADDR) || (word >= DEPTH32);
    effIdx   = word[AW-1:0];
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE, ACK: begin
        stateNext = IDLE;
        if (accept) begin
          if (LATENCY == 0) begin
            stateNext = ACK;
            commit    = 1'b1;
          end else begin
            stateNext = WAIT;
            cntNext   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          stateNext = ACK;
          commit    = 1'b1;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addrReg   <= 32'd0;
      dataReg   <= 32'd0;
      writeReg  <= 1'b0;
      byteEnReg <= 4'd0;
    end else if (accept) begin
      addrReg   <= bus.iAddr;
      dataReg   <= bus.iWriteData;
      writeReg  <= bus.iWrite;
      byteEnReg <= bus.iByteEn;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readData <= 32'd0;
      errReg   <= 1'b0;
    end else if (commit) begin
      errReg <= effError;
      if (!effWrite) readData <= effError ? 32'd0 : mem[effIdx];
    end
  end

  // RAM has no reset; gating on reset keeps a request presented during reset from landing.
  always_ff @(posedge clk) begin
    if (!reset && commit && effWrite && !effError) begin
      for (int b = 0; b < 4; b++) begin
        if (effByteEn[b]) mem[effIdx][8*b +: 8] <= effData[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_hs.sv
// Scoreboard bench for data_mem_hs: five instances with different latency/base settings,
// directed scenarios plus random traffic checked against a word/byte-valid reference model.
module tb_data_mem_hs;

  localparam int NI = 5;

  function automatic int latOf(input int g);
    if (g == 0) return 2;
    if (g == 1) return 3;
    if (g == 2) return 0;
    if (g == 3) return 5;
    return 15;
  endfunction

  function automatic logic [31:0] baseOf(input int g);
    return (g == 1) ? 32'h0000_1000 : 32'h0000_0000;
  endfunction

  typedef struct {
    int          inst;
    bit          isWrite;
    bit          err;
    logic [31:0] data;
    logic [31:0] mask;
    int          ackCyc;
  } exp_t;

  logic clk = 1'b0;
  logic [NI-1:0] rst = '1;
  logic [NI-1:0] req = '0;
  logic [NI-1:0] wr  = '0;
  logic [NI-1:0] readyV, ackV, errV;
  logic [31:0]   addrV [NI];
  logic [31:0]   wdataV[NI];
  logic [31:0]   rdataV[NI];
  logic [3:0]    beV   [NI];

  logic [31:0] refMem[NI][256];
  logic [3:0]  refVld[NI][256];
  exp_t        sbq[$];
  exp_t        monE;

  int cyc = 0;
  int nChecks = 0;
  int nFail = 0;
  int waited;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_hs_if ifc[NI] ();

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign ifc[g].iReq       = req[g];
    assign ifc[g].iWrite     = wr[g];
    assign ifc[g].iAddr      = addrV[g];
    assign ifc[g].iByteEn    = beV[g];
    assign ifc[g].iWriteData = wdataV[g];
    assign readyV[g]         = ifc[g].oReady;
    assign ackV[g]           = ifc[g].oAck;
    assign errV[g]           = ifc[g].oError;
    assign rdataV[g]         = ifc[g].oReadData;

    data_mem_hs #(
      .DEPTH_WORDS(256),
      .LATENCY    (latOf(g)),
      .BASE_ADDR  (baseOf(g))
    ) u_dut (
      .clk  (clk),
      .reset(rst[g]),
      .bus  (ifc[g])
    );
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: pops one expectation per oAck pulse.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (ackV[g]) begin
        if (sbq.size() == 0) begin
          check($sformatf("unexpected ack inst%0d", g), 32'(ackV[g]), 32'd0);
        end else begin
          monE = sbq.pop_front();
          check("ack instance", 32'(g), 32'(monE.inst));
          check("ack cycle", 32'(cyc), 32'(monE.ackCyc));
          check("oError", 32'(errV[g]), 32'(monE.err));
          if (!monE.isWrite && monE.mask != 32'd0)
            check("oReadData", rdataV[g] & monE.mask, monE.data & monE.mask);
        end
      end else if (errV[g]) begin
        check($sformatf("oError without oAck inst%0d", g), 32'(errV[g]), 32'd0);
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge with iReq still high.
  task automatic issue(input int g, input bit w, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] d, output int nWait);
    exp_t   e;
    longint off;
    int     word;
    req[g] = 1'b1; wr[g] = w; addrV[g] = a; beV[g] = be; wdataV[g] = d;
    nWait = 0;
    @(negedge clk);
    while (!readyV[g] && nWait < 50) begin
      @(negedge clk);
      nWait++;
    end
    if (!readyV[g]) begin
      check("accept timeout", 32'(readyV[g]), 32'd1);
      req[g] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    off  = longint'(a) - longint'(baseOf(g));
    e.inst    = g;
    e.isWrite = w;
    e.err     = (off < 0) || (off / 4 >= 256);
    e.ackCyc  = cyc + latOf(g);
    e.data    = 32'd0;
    e.mask    = 32'hFFFF_FFFF;
    word = e.err ? 0 : int'(off / 4);
    if (!e.err) begin
      if (w) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) begin
            refMem[g][word][8*b +: 8] = d[8*b +: 8];
            refVld[g][word][b] = 1'b1;
          end
        end
      end else begin
        e.data = refMem[g][word];
        for (int b = 0; b < 4; b++) e.mask[8*b +: 8] = {8{refVld[g][word][b]}};
      end
    end
    sbq.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sbq.size()), 32'd0);
    sbq.delete();
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] randAddr(input int g);
    logic [31:0] b = baseOf(g);
    int unsigned r = $urandom_range(0, 9);
    if (r == 0) return b + 32'd1024 + 32'($urandom_range(0, 15)) * 32'd4;
    if (r == 1 && b != 32'd0) return b - 32'd4 + 32'($urandom_range(0, 3));
    return b + 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int g = 0; g < NI; g++) begin
      addrV[g] = '0; wdataV[g] = '0; beV[g] = '0;
      for (int k = 0; k < 256; k++) begin
        refMem[g][k] = '0;
        refVld[g][k] = '0;
      end
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check("reset oAck", 32'(ackV[g]), 32'd0);
      check("reset oError", 32'(errV[g]), 32'd0);
      check("reset oReadData", rdataV[g], 32'd0);
    end
    rst = '0;
    @(negedge clk);
    for (int g = 0; g < NI; g++) check("oReady after reset", 32'(readyV[g]), 32'd1);
    @(posedge clk);
    #1;

    // Basic store/load with two wait states.
    issue(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, waited);
    req[0] = 1'b0;
    @(negedge clk); check("oReady wait1", 32'(readyV[0]), 32'd0);
    @(negedge clk); check("oReady wait2", 32'(readyV[0]), 32'd0);
    @(negedge clk); check("oReady in ack", 32'(readyV[0]), 32'd1);
    check("oAck at E0+2", 32'(ackV[0]), 32'd1);
    @(posedge clk); #1;
    issue(0, 1'b0, 32'h10, 4'h0, 32'h0, waited);
    req[0] = 1'b0;
    drain();

    // Byte lanes, back-to-back through the ACK cycle.
    issue(0, 1'b1, 32'h20, 4'hF, 32'h1122_3344, waited);
    issue(0, 1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD, waited);
    issue(0, 1'b0, 32'h20, 4'h0, 32'h0, waited);
    issue(0, 1'b1, 32'h24, 4'h0, 32'hFFFF_FFFF, waited);
    req[0] = 1'b0;
    drain();

    // Range errors around BASE 0x1000.
    issue(1, 1'b1, 32'h13FC, 4'hF, 32'h7777_1234, waited);
    issue(1, 1'b0, 32'h0FFC, 4'h0, 32'h0, waited);
    issue(1, 1'b0, 32'h1400, 4'h0, 32'h0, waited);
    issue(1, 1'b1, 32'h1400, 4'hF, 32'hBAD0_BAD0, waited);
    issue(1, 1'b0, 32'h13FC, 4'h0, 32'h0, waited);
    req[1] = 1'b0;
    drain();

    // Zero-latency streaming with iReq held high.
    issue(2, 1'b1, 32'h0, 4'hF, 32'h5, waited);
    check("stream accept 1 wait", 32'(waited), 32'd0);
    issue(2, 1'b0, 32'h0, 4'h0, 32'h0, waited);
    check("stream accept 2 wait", 32'(waited), 32'd0);
    issue(2, 1'b0, 32'h4, 4'h0, 32'h0, waited);
    check("stream accept 3 wait", 32'(waited), 32'd0);
    req[2] = 1'b0;
    drain();

    // Reset during the third wait cycle of a LATENCY=5 store.
    issue(3, 1'b1, 32'h8, 4'hF, 32'h1, waited);
    issue(3, 1'b0, 32'h8, 4'h0, 32'h0, waited);
    req[3] = 1'b0;
    drain();
    req[3] = 1'b1; wr[3] = 1'b1; addrV[3] = 32'h8; beV[3] = 4'hF; wdataV[3] = 32'hFFFF_FFFF;
    @(negedge clk);
    check("abort store ready", 32'(readyV[3]), 32'd1);
    @(posedge clk); #1;
    req[3] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst[3] = 1'b1;
    #1;
    check("mid reset oAck", 32'(ackV[3]), 32'd0);
    check("mid reset oError", 32'(errV[3]), 32'd0);
    check("mid reset oReadData", rdataV[3], 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst[3] = 1'b0;
    @(negedge clk);
    check("oReady after mid reset", 32'(readyV[3]), 32'd1);
    @(posedge clk); #1;
    issue(3, 1'b0, 32'h8, 4'h0, 32'h0, waited);
    req[3] = 1'b0;
    drain();

    // Maximum latency.
    issue(4, 1'b1, 32'h40, 4'hF, 32'hCAFE_F00D, waited);
    req[4] = 1'b0;
    drain();
    issue(4, 1'b0, 32'h40, 4'h0, 32'h0, waited);
    req[4] = 1'b0;
    drain();

    // Random traffic with random gaps.
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 40; k++) begin
        issue(g, 1'($urandom_range(0, 1)), randAddr(g), 4'($urandom_range(0, 15)), $urandom, waited);
        if ($urandom_range(0, 2) == 0) begin
          req[g] = 1'b0;
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
      req[g] = 1'b0;
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/data_mem_hs.md
Name: data_mem_hs

Overview:
Parametrised successor to the fixed single-cycle data memory. It is a word-organised data RAM with a request/acknowledge handshake, programmable wait-state latency, byte-lane write enables and range-error reporting. It sits between the multi-cycle or pipelined core's load/store port and storage. The core stalls on oReady and oAck instead of assuming single-cycle access.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; power of two, 16..65536
LATENCY, 2, wait cycles between request acceptance and acknowledge; 0..15
BASE_ADDR, 32'h0000_0000, byte address of word 0; word aligned

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
iReq  input  1  request valid; accepted on a rising edge where iReq & oReady
iWrite  input  1  1 = store, 0 = load; sampled at accept
iAddr  input  32  byte address; bits [1:0] ignored; sampled at accept
iByteEn  input  4  write lane enables, bit n selects bits [8n+7:8n]; ignored for loads
iWriteData  input  32  store data; sampled at accept
oReady  output  1  block can accept a request this cycle
oAck  output  1  one-cycle completion pulse
oReadData  output  32  load result; valid while oAck & ~iWrite of that request; holds until next load completes
oError  output  1  qualifies oAck: address out of range

Behaviour:
- FSM states: IDLE, WAIT, ACK. A 4-bit wait counter `cnt` drives it.
- The request registers are addr, write, byteEn and data. They are captured on the accept edge.
- Range check is done on the captured address. word = (addr − BASE_ADDR) >> 2. Error if addr < BASE_ADDR or word ≥ DEPTH_WORDS.
- Transitions from IDLE on accept:
  - LATENCY = 0: go to ACK.
  - Otherwise: go to WAIT, with cnt = LATENCY − 1.
- WAIT: cnt decrements each cycle. When cnt == 0, go to ACK.
- ACK: oAck = 1 for exactly this cycle.
  - If accepted again at the closing edge, go to ACK (LATENCY = 0) or WAIT.
  - Otherwise go to IDLE.
- oReady = 1 in IDLE and ACK, and 0 in WAIT. This allows back-to-back requests. LATENCY = 0 sustains one transaction per cycle.
- Latency: if accept is at edge E0, oAck is high during the cycle after edge E0 + LATENCY.
- Commit: memory is written, and oReadData loaded, on the edge that enters ACK.
  - Stores: write only the enabled lanes. iByteEn = 0 is a legal no-op store that still acks.
  - Loads: oReadData = mem[word].
  - A load accepted in the ACK cycle of a store to the same word returns the newly written data.
- Error requests:
  - Ack with normal latency and oError = 1.
  - No memory write. A load sets oReadData = 0.
  - oError = 0 whenever oAck = 0.
- Inputs are ignored while oReady = 0. iReq held high in WAIT is not double-counted.
- Reset (asynchronous, any state):
  - state = IDLE, cnt = 0.
  - oAck = 0, oError = 0, oReadData = 0, oReady = 1 after release.
  - An in-flight store that has not yet reached ACK is aborted and memory is not modified.
  - RAM contents are not cleared by reset and are undefined until written.
- Width rules: internal address arithmetic is 32-bit unsigned, with no wrap. BASE_ADDR + 4·DEPTH_WORDS is required to be ≤ 2^32.

Test Plan:
- LATENCY=2, BASE=0: store 0xDEADBEEF to 0x10 with BE=1111, accepted at E0 → oAck at E2, oReady low during E1..E2. Then load 0x10 → oReadData = 0xDEADBEEF, oError = 0.
- Byte lanes: store 0x11223344 to 0x20 with BE=1111, then store 0xAABBCCDD with BE=0101 → load 0x20 returns 0x11BB33DD.
- Range: DEPTH=256, BASE=0x1000. Load 0x0FFC and load 0x1400 → each acks with oError=1, oReadData=0. Store to 0x1400 leaves 0x13FC unchanged.
- LATENCY=0 streaming, iReq held high: store 0x5 to 0x0, then load 0x0, then load 0x4 on consecutive cycles → three consecutive oAck pulses, oReady stays 1, and the first load returns 0x5.
- Reset mid-operation: LATENCY=5, store 0xFFFFFFFF to 0x8 over a prior value of 0x1. Assert reset during the 3rd wait cycle → outputs are 0 immediately and oReady=1 after release. A subsequent load 0x8 returns 0x1.
- Max latency: LATENCY=15, single load → oAck exactly 15 cycles after accept, with exactly one pulse.
